mem_access_ctrl: RTL

- Parametrised, multi-cycle successor to the single-cycle memory-stage decoder.
- Sits between the ALU result and data memory. Turns load/store flags into a registered request with a ready handshake toward memory.
- Handles byte, half and word access with byte enables, store-data lane steering, and load sign/zero extension.
- Detects misalignment and memory timeouts, and stalls the pipeline while an access is outstanding.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_load_align.sv | 38 +++
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data-memory access path.
// Used by the access controller and by the load-alignment unit.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = 4'b0011 << offset;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Illegal size is treated like a misaligned address: both abort before any strobe.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] steer_store(input logic [1:0] size, input logic [1:0] offset,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {24'h000000, data[7:0]} << {offset, 3'b000};
            SZ_HALF: lanes = {16'h0000, data[15:0]} << {offset, 3'b000};
            SZ_WORD: lanes = data;
            default: lanes = 32'h0000_0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extract-and-extend: picks the addressed byte/half/word
// out of a read word and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted_s;

    // Right-justify the addressed lanes, then extend to the access width.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (size)
            SZ_BYTE: begin
                if (load_unsigned) begin
                    result = {24'h000000, shifted_s[7:0]};
                end else begin
                    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_HALF: begin
                if (load_unsigned) begin
                    result = {16'h0000, shifted_s[15:0]};
                end else begin
                    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_WORD: result = rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory-stage controller: registers a load/store request, holds the
// strobe until mem_ready or timeout, and reports done / misaligned / timeout_err.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_Flag,
    input  logic              store_Flag,
    input  logic [1:0]        acc_size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] alu_Result,
    input  logic [31:0]       store_data,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_destination,
    output logic              memRead,
    output logic              data_memory_write,
    output logic [3:0]        mem_byte_en,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output logic              timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]        state_r;
    logic [TO_W-1:0]   cnt_r;
    logic              is_load_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [1:0]        off_r;
    logic [ADDR_W-1:0] dest_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [3:0]        byte_en_r;
    logic [31:0]       wdata_r;
    logic [31:0]       load_data_r;
    logic              done_r;
    logic              misaligned_r;
    logic              timeout_r;

    logic              req_s;
    logic              is_load_s;
    logic [1:0]        off_s;
    logic              illegal_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       aligned_s;
    logic              stall_s;

    // Decode the incoming request; a load wins over a simultaneous store.
    always_comb begin
        req_s     = load_Flag | store_Flag;
        is_load_s = load_Flag;
        off_s     = alu_Result[1:0];
        illegal_s = is_misaligned(acc_size, off_s);
        be_s      = lane_enable(acc_size, off_s);
        wdata_s   = steer_store(acc_size, off_s, store_data);
    end

    mem_load_align u_align (
        .rdata         (mem_rdata),
        .offset        (off_r),
        .size          (size_r),
        .load_unsigned (uns_r),
        .result        (aligned_s)
    );

    // Stall is combinational in IDLE so the pipeline holds in the request cycle itself.
    always_comb begin
        case (state_r)
            ST_IDLE: stall_s = req_s;
            ST_BUSY: stall_s = 1'b1;
            ST_FIN:  stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM with registered strobes, lane data and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            is_load_r    <= 1'b0;
            size_r       <= SZ_BYTE;
            uns_r        <= 1'b0;
            off_r        <= 2'b00;
            dest_r       <= '0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            byte_en_r    <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            load_data_r  <= 32'h0000_0000;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            timeout_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s && illegal_s) begin
                        state_r      <= ST_FIN;
                        misaligned_r <= 1'b1;
                    end else if (req_s) begin
                        state_r     <= ST_BUSY;
                        cnt_r       <= '0;
                        is_load_r   <= is_load_s;
                        size_r      <= acc_size;
                        uns_r       <= load_unsigned;
                        off_r       <= off_s;
                        dest_r      <= {alu_Result[ADDR_W-1:2], 2'b00};
                        mem_read_r  <= is_load_s;
                        mem_write_r <= ~is_load_s;
                        byte_en_r   <= be_s;
                        wdata_r     <= wdata_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // A ready arriving on the last allowed cycle beats the timeout.
                    if (mem_ready) begin
                        state_r     <= ST_FIN;
                        done_r      <= 1'b1;
                        cnt_r       <= '0;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        byte_en_r   <= 4'b0000;
                        if (is_load_r) begin
                            load_data_r <= aligned_s;
                        end else begin
                            load_data_r <= load_data_r;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_FIN;
                        timeout_r   <= 1'b1;
                        cnt_r       <= '0;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        byte_en_r   <= 4'b0000;
                    end else begin
                        cnt_r <= cnt_r + TO_W'(1);
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    byte_en_r   <= 4'b0000;
                end
            endcase
        end
    end

    assign mem_destination   = dest_r;
    assign memRead           = mem_read_r;
    assign data_memory_write = mem_write_r;
    assign mem_byte_en       = byte_en_r;
    assign mem_wdata         = wdata_r;
    assign load_data         = load_data_r;
    assign stall             = stall_s;
    assign done              = done_r;
    assign misaligned        = misaligned_r;
    assign timeout_err       = timeout_r;

endmodule
